// File: rtl/pca9685_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pca9685_reg_ctrl
// Description : Register-access sequencer between the I2C slave byte layer and
//               a PCA9685-style register file (pointer load, writes, prefetched
//               reads, MODE1.AI auto-increment with roll-over).
// Revision    : 1.0 - initial release
// ============================================================================
module pca9685_reg_ctrl #(
   parameter logic [7:0] LED_LAST  = 8'h45,
   parameter logic [7:0] ALL_FIRST = 8'hFA,
   parameter logic [7:0] ALL_LAST  = 8'hFD
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       xfer_start_i,
   input  logic       xfer_rw_i,
   input  logic       xfer_stop_i,
   input  logic       wr_valid_i,
   input  logic [7:0] wr_byte_i,
   input  logic       rd_ack_i,
   output logic [7:0] rd_byte_o,
   output logic       rd_valid_o,
   input  logic       ai_i,
   output logic [7:0] reg_addr_o,
   output logic [7:0] reg_wdata_o,
   output logic       reg_we_o,
   output logic       reg_re_o,
   input  logic [7:0] reg_rdata_i,
   output logic       busy_o
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_GET_PTR  = 3'd1,
      S_WRITE    = 3'd2,
      S_RD_FETCH = 3'd3,
      S_RD_WAIT  = 3'd4,
      S_RD_HOLD  = 3'd5
   } state_t;

   state_t     r_state;
   state_t     w_next;
   logic [7:0] r_ptr;
   logic [7:0] r_rd_byte;
   logic       r_rd_valid;
   logic       r_we;
   logic [7:0] r_wdata;
   logic       w_ptr_load;
   logic       w_wr_accept;
   logic       w_rd_ack;

   // Auto-increment with the two PCA9685 roll-over windows; outside them the
   // pointer is frozen.
   function automatic logic [7:0] f_next(input logic [7:0] p, input logic ai);
      logic [7:0] n;
      n = p;
      if (ai) begin
         if (p == LED_LAST)
            n = 8'h00;
         else if (p == ALL_LAST)
            n = ALL_FIRST;
         else if ((p < LED_LAST) || ((p >= ALL_FIRST) && (p < ALL_LAST)))
            n = p + 8'd1;
      end
      return n;
   endfunction

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   // A repeated START overrides everything, including a byte strobe in the same cycle.
   always_comb begin
      w_next = r_state;
      if (xfer_start_i)
         w_next = xfer_rw_i ? S_RD_FETCH : S_GET_PTR;
      else if (xfer_stop_i)
         w_next = S_IDLE;
      else begin
         case (r_state)
            S_GET_PTR:  if (wr_valid_i) w_next = S_WRITE;
            S_RD_FETCH: w_next = S_RD_WAIT;
            S_RD_WAIT:  w_next = S_RD_HOLD;
            S_RD_HOLD:  if (rd_ack_i) w_next = S_RD_FETCH;
            default:    w_next = r_state;
         endcase
      end
   end

   assign w_ptr_load  = wr_valid_i && !xfer_start_i && (r_state == S_GET_PTR);
   assign w_wr_accept = wr_valid_i && !xfer_start_i && (r_state == S_WRITE);
   assign w_rd_ack    = rd_ack_i   && !xfer_start_i && (r_state == S_RD_HOLD);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_ptr      <= 8'h00;
         r_rd_byte  <= 8'h00;
         r_rd_valid <= 1'b0;
         r_we       <= 1'b0;
         r_wdata    <= 8'h00;
      end else begin
         r_we <= w_wr_accept;
         if (w_wr_accept)
            r_wdata <= wr_byte_i;

         // The write strobe cycle advances the pointer for the following byte.
         if (w_ptr_load)
            r_ptr <= wr_byte_i;
         else if (r_we || w_rd_ack)
            r_ptr <= f_next(r_ptr, ai_i);

         if (xfer_start_i || xfer_stop_i)
            r_rd_valid <= 1'b0;
         else if (r_state == S_RD_WAIT) begin
            r_rd_byte  <= reg_rdata_i;
            r_rd_valid <= 1'b1;
         end else if (w_rd_ack)
            r_rd_valid <= 1'b0;
      end
   end

   assign reg_addr_o  = r_ptr;
   assign reg_wdata_o = r_wdata;
   assign reg_we_o    = r_we;
   assign reg_re_o    = (r_state == S_RD_FETCH);
   assign rd_byte_o   = r_rd_byte;
   assign rd_valid_o  = r_rd_valid;
   assign busy_o      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pca9685_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pca9685_reg_ctrl
// Description : Scoreboard bench for pca9685_reg_ctrl with a transaction-level
//               pointer/register model and a bench-side register file.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pca9685_reg_ctrl;

   localparam int K_WE = 0;
   localparam int K_RE = 1;
   localparam int K_RD = 2;

   typedef struct packed {
      logic [1:0] kind;
      logic [7:0] addr;
      logic [7:0] data;
   } ev_t;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic       xfer_start_i = 1'b0;
   logic       xfer_rw_i = 1'b0;
   logic       xfer_stop_i = 1'b0;
   logic       wr_valid_i = 1'b0;
   logic [7:0] wr_byte_i = 8'h00;
   logic       rd_ack_i = 1'b0;
   logic       ai_i = 1'b1;
   logic [7:0] reg_rdata_i = 8'h00;
   logic [7:0] rd_byte_o;
   logic       rd_valid_o;
   logic [7:0] reg_addr_o;
   logic [7:0] reg_wdata_o;
   logic       reg_we_o;
   logic       reg_re_o;
   logic       busy_o;

   int         n_checks = 0;
   int         n_fail = 0;
   ev_t        q[$];
   logic [7:0] m_mem [256];
   logic [7:0] dut_mem [256];
   logic [7:0] m_ptr = 8'h00;
   logic [7:0] wbuf [8];
   logic       prev_valid = 1'b0;

   always #5 clk_i = ~clk_i;

   pca9685_reg_ctrl dut (
      .clk_i(clk_i), .rst_i(rst_i), .xfer_start_i(xfer_start_i), .xfer_rw_i(xfer_rw_i),
      .xfer_stop_i(xfer_stop_i), .wr_valid_i(wr_valid_i), .wr_byte_i(wr_byte_i),
      .rd_ack_i(rd_ack_i), .rd_byte_o(rd_byte_o), .rd_valid_o(rd_valid_o), .ai_i(ai_i),
      .reg_addr_o(reg_addr_o), .reg_wdata_o(reg_wdata_o), .reg_we_o(reg_we_o),
      .reg_re_o(reg_re_o), .reg_rdata_i(reg_rdata_i), .busy_o(busy_o)
   );

   // Bench register file: read data one cycle after the read strobe.
   always @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < 256; i++) dut_mem[i] <= 8'((i * 37 + 11) % 256);
      end else begin
         if (reg_we_o) dut_mem[reg_addr_o] <= reg_wdata_o;
         if (reg_re_o) reg_rdata_i <= dut_mem[reg_addr_o];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Pointer rule stated directly over address ranges.
   function automatic logic [7:0] m_next(input int p, input logic a);
      if (!a) return 8'(p);
      if (p == 'h45) return 8'h00;
      if (p == 'hFD) return 8'hFA;
      if (p inside {[0:'h44], ['hFA:'hFC]}) return 8'(p + 1);
      return 8'(p);
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 256; i++) m_mem[i] = 8'((i * 37 + 11) % 256);
      m_ptr = 8'h00;
   endtask

   task automatic push(input int kind, input logic [7:0] addr, input logic [7:0] data);
      ev_t e;
      e.kind = 2'(kind);
      e.addr = addr;
      e.data = data;
      q.push_back(e);
   endtask

   task automatic pop_cmp(input int kind, input string name);
      ev_t e;
      if (q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s unexpected event actual=present required=none at %0t", name, $time);
      end else begin
         e = q.pop_front();
         chk({name, "_kind"}, 32'(kind), 32'(e.kind));
         if (kind == K_RD) chk({name, "_data"}, 32'(rd_byte_o), 32'(e.data));
         else chk({name, "_addr"}, 32'(reg_addr_o), 32'(e.addr));
         if (kind == K_WE) chk({name, "_data"}, 32'(reg_wdata_o), 32'(e.data));
      end
   endtask

   always @(negedge clk_i) begin
      if (rst_i) prev_valid = 1'b0;
      else begin
         if (reg_we_o || reg_re_o) chk("we_re_exclusive", 32'(reg_we_o & reg_re_o), 0);
         if (reg_we_o) pop_cmp(K_WE, "reg_write");
         if (reg_re_o) pop_cmp(K_RE, "reg_read");
         if (rd_valid_o && !prev_valid) pop_cmp(K_RD, "rd_byte");
         prev_valid = rd_valid_o;
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic pulse_start(input logic rw);
      xfer_start_i = 1'b1;
      xfer_rw_i    = rw;
      tick();
      xfer_start_i = 1'b0;
      xfer_rw_i    = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      int cnt = 0;
      while (!rd_valid_o && cnt < 20) begin
         tick();
         cnt++;
      end
      chk(name, 32'(cnt), 2);
   endtask

   // stop_mode: 0 = leave open for Sr, 1 = separate STOP, 2 = STOP with last byte
   task automatic do_write(input logic [7:0] p, input int n, input int stop_mode);
      pulse_start(1'b0);
      tick();
      wr_byte_i  = p;
      wr_valid_i = 1'b1;
      if (stop_mode == 2 && n == 0) xfer_stop_i = 1'b1;
      tick();
      wr_valid_i  = 1'b0;
      xfer_stop_i = 1'b0;
      m_ptr = p;
      for (int i = 0; i < n; i++) begin
         tick();
         tick();
         push(K_WE, m_ptr, wbuf[i]);
         m_mem[m_ptr] = wbuf[i];
         m_ptr = m_next(int'(m_ptr), ai_i);
         wr_byte_i  = wbuf[i];
         wr_valid_i = 1'b1;
         if (stop_mode == 2 && i == n - 1) xfer_stop_i = 1'b1;
         tick();
         wr_valid_i  = 1'b0;
         xfer_stop_i = 1'b0;
      end
      if (stop_mode == 1) begin
         tick();
         xfer_stop_i = 1'b1;
         tick();
         xfer_stop_i = 1'b0;
      end
      tick();
      tick();
      if (stop_mode != 0) begin
         chk("write_idle_busy", 32'(busy_o), 0);
         chk("write_queue_drain", 32'(q.size()), 0);
      end
   endtask

   // stop_mode: 0 = leave in hold, 1 = separate STOP, 2 = STOP with last ACK
   task automatic do_read(input int n, input int stop_mode, input logic flip_ai);
      push(K_RE, m_ptr, 8'h00);
      push(K_RD, 8'h00, m_mem[m_ptr]);
      pulse_start(1'b1);
      wait_valid("rd_latency_start");
      for (int i = 0; i < n; i++) begin
         tick();
         if (flip_ai) ai_i = 1'($urandom_range(0, 1));
         m_ptr = m_next(int'(m_ptr), ai_i);
         rd_ack_i = 1'b1;
         if (stop_mode == 2 && i == n - 1) begin
            xfer_stop_i = 1'b1;
            tick();
            rd_ack_i    = 1'b0;
            xfer_stop_i = 1'b0;
         end else begin
            push(K_RE, m_ptr, 8'h00);
            push(K_RD, 8'h00, m_mem[m_ptr]);
            tick();
            rd_ack_i = 1'b0;
            chk("rd_valid_drop", 32'(rd_valid_o), 0);
            wait_valid("rd_latency_ack");
         end
      end
      if (stop_mode == 1) begin
         tick();
         xfer_stop_i = 1'b1;
         tick();
         xfer_stop_i = 1'b0;
      end
      tick();
      tick();
      if (stop_mode != 0) begin
         chk("read_idle_busy", 32'(busy_o), 0);
         chk("read_valid_low", 32'(rd_valid_o), 0);
      end
      chk("read_queue_drain", 32'(q.size()), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      m_reset();
      repeat (3) @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      chk("rst_rd_byte", 32'(rd_byte_o), 0);
      chk("rst_rd_valid", 32'(rd_valid_o), 0);
      chk("rst_we", 32'(reg_we_o), 0);
      chk("rst_re", 32'(reg_re_o), 0);
      chk("rst_wdata", 32'(reg_wdata_o), 0);
      chk("rst_busy", 32'(busy_o), 0);
      chk("rst_addr", 32'(reg_addr_o), 0);
      tick();

      ai_i = 1'b1;
      wbuf[0] = 8'hAA; wbuf[1] = 8'hBB;
      do_write(8'h06, 2, 1);
      do_read(1, 1, 1'b0);                 // continues from pointer 0x08
      wbuf[0] = 8'h11; wbuf[1] = 8'h22;
      do_write(8'h45, 2, 1);
      do_write(8'hFD, 2, 1);
      wbuf[0] = 8'h05; wbuf[1] = 8'h06; wbuf[2] = 8'h07;
      do_write(8'h02, 3, 1);
      do_write(8'h02, 0, 0);
      do_read(3, 1, 1'b0);
      ai_i = 1'b0;
      wbuf[0] = 8'h01; wbuf[1] = 8'h02;
      do_write(8'h10, 2, 1);
      do_read(3, 1, 1'b0);
      ai_i = 1'b1;
      wbuf[0] = 8'h31; wbuf[1] = 8'h32; wbuf[2] = 8'h33;
      do_write(8'h50, 3, 1);
      do_read(2, 2, 1'b0);
      wbuf[0] = 8'h09; wbuf[1] = 8'h08;
      do_write(8'h20, 2, 2);
      do_write(8'h30, 0, 2);
      do_read(1, 0, 1'b0);                 // Sr straight out of the hold state
      do_read(1, 1, 1'b0);

      do_write(8'h33, 0, 2);
      do_read(2, 0, 1'b0);
      #2;
      rst_i = 1'b1;
      #1;
      chk("async_rst_valid", 32'(rd_valid_o), 0);
      chk("async_rst_busy", 32'(busy_o), 0);
      chk("async_rst_addr", 32'(reg_addr_o), 0);
      chk("async_rst_re", 32'(reg_re_o), 0);
      repeat (2) @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      m_reset();
      tick();
      do_read(1, 1, 1'b0);

      for (int it = 0; it < 40; it++) begin
         int         sel;
         int         kind;
         logic [7:0] p;
         ai_i = ($urandom_range(0, 3) != 0);
         sel  = int'($urandom_range(0, 3));
         case (sel)
            0:       p = 8'($urandom_range(0, 'h45));
            1:       p = 8'($urandom_range('h42, 'h47));
            2:       p = 8'($urandom_range('hF8, 'hFF));
            default: p = 8'($urandom_range(0, 255));
         endcase
         for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom_range(0, 255));
         kind = int'($urandom_range(0, 2));
         if (kind == 0)
            do_write(p, int'($urandom_range(1, 4)), int'($urandom_range(1, 2)));
         else begin
            if (kind == 1) do_write(p, 0, 0);
            do_read(int'($urandom_range(1, 4)), int'($urandom_range(1, 2)), 1'($urandom_range(0, 1)));
         end
      end

      chk("final_queue_empty", 32'(q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
